mult_result_buffer: RTL and testbench

- Output-side flow-control stage for the pipelined Wallace tree multiplier.
- The multiplier datapath is a fixed-latency, non-stallable register chain. This block gates operand issue with credits, tracks in-flight products with a valid shift register, and captures each product as it leaves the chain.
- Captured products are buffered in a FIFO drained by a valid/ready consumer, so no result is lost under downstream backpressure.

---
 rtl/mult_result_buffer.sv | 98 +++++++++
 tb/tb_mult_result_buffer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_result_buffer.sv
// mult_result_buffer
// Output-side flow control for the pipelined Wallace tree multiplier.
// The multiplier pipe is a fixed-latency register chain that cannot stall.
// This block issues operands only while a result slot is guaranteed. It
// tracks each issued product through the pipe with a valid shift register
// and captures it into a first-word-fall-through FIFO as it emerges.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   in_valid   producer has operands this cycle
//   in_ready   block grants issue this cycle
//   issue      in_valid & in_ready; operands enter the multiplier pipe
//   res_data   multiplier pipe output
//   out_valid  FIFO head holds a product
//   out_ready  consumer accepts the head this cycle
//   out_data   FIFO head product
//   fifo_count entries held in the FIFO
//   inflight   products issued but not yet captured
module mult_result_buffer #(
  parameter int WIDTH   = 10,
  parameter int LATENCY = 5,
  parameter int DEPTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       issue,
  input  logic [WIDTH-1:0]           res_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic [$clog2(DEPTH+1)-1:0] inflight
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);

  logic [LATENCY-1:0] vld;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic               capture;
  logic               pop;
  logic [CW:0]        credit_used;

  // Every issued product owns either a pipe slot or a FIFO entry, so the
  // sum of registered counts is the committed FIFO occupancy. Issuing only
  // while it is below DEPTH makes FIFO overflow impossible.
  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
  assign in_ready    = rst & (credit_used < (CW+1)'(DEPTH));
  assign issue       = in_valid & in_ready;

  assign capture   = vld[LATENCY-1];
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid & out_ready;
  assign out_data  = mem[rd_ptr];

  // Stage boundary: valid shadow of the multiplier pipe and all counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld        <= '0;
      inflight   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      vld[0] <= issue;
      for (int k = 1; k < LATENCY; k++) begin
        vld[k] <= vld[k-1];
      end

      case ({issue, capture})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase

      case ({capture, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase

      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (capture) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Stage boundary: FIFO storage, data only, never reset
  always_ff @(posedge clk) begin
    if (capture) mem[wr_ptr] <= res_data;
  end

endmodule

// File: tb/tb_mult_result_buffer.sv
module tb_mult_result_buffer;

  localparam int WIDTH   = 10;
  localparam int LATENCY = 5;
  localparam int DEPTH   = 8;
  localparam int CW      = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             issue;
  logic [WIDTH-1:0] res_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    fifo_count;
  logic [CW-1:0]    inflight;

  logic [WIDTH-1:0]   tag = '0;
  logic [WIDTH-1:0]   mpipe [LATENCY];
  logic [LATENCY-1:0] mvld;

  int vectors = 0;
  int errors  = 0;

  mult_result_buffer #(.WIDTH(WIDTH), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .issue     (issue),
    .res_data  (res_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .fifo_count(fifo_count),
    .inflight  (inflight)
  );

  always #5 clk = ~clk;

  // Multiplier pipe stand-in: the tag offered on an issue cycle appears on
  // res_data LATENCY cycles later; non-issue slots carry zero.
  always @(posedge clk) begin
    mpipe[0] <= issue ? tag : '0;
    for (int k = 1; k < LATENCY; k++) mpipe[k] <= mpipe[k-1];
  end
  assign res_data = mpipe[LATENCY-1];

  // Independent tracker of when a product leaves the pipe; a capture into
  // a full FIFO would be a lost product.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mvld <= '0;
    end else begin
      if (mvld[LATENCY-1]) begin
        vectors++;
        assert (fifo_count !== CW'(DEPTH)) else begin
          errors++;
          $error("FAIL overflow observed fifo_count=%0d at capture, expected below %0d", fifo_count, DEPTH);
        end
      end
      mvld <= {mvld[LATENCY-2:0], issue};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  int nout;
  int peak_inf;
  int peak_fifo;

  initial begin
    // 1: reset, with in_valid asserted to prove issue is blocked
    in_valid = 1'b1;
    settle();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_issue", 32'(issue), 0);
    next();
    next();
    check("rst_fifo_count", 32'(fifo_count), 0);
    check("rst_inflight", 32'(inflight), 0);
    in_valid = 1'b0;
    rst = 1'b1;
    settle();
    check("rel_in_ready", 32'(in_ready), 1);

    // 2: single product 0x2A, issued in the first cycle after release
    in_valid = 1'b1;
    tag = 10'h02A;
    settle();
    check("single_issue", 32'(issue), 1);
    next();
    in_valid = 1'b0;
    for (int i = 1; i <= LATENCY; i++) begin
      settle();
      check("single_wait_valid", 32'(out_valid), 0);
      check("single_inflight", 32'(inflight), 1);
      next();
    end
    settle();
    check("single_out_valid", 32'(out_valid), 1);
    check("single_out_data", 32'(out_data), 32'h02A);
    check("single_count", 32'(fifo_count), 1);
    check("single_inflight_done", 32'(inflight), 0);
    out_ready = 1'b1;
    next();
    out_ready = 1'b0;
    settle();
    check("single_pop_count", 32'(fifo_count), 0);
    check("single_pop_valid", 32'(out_valid), 0);

    // 3: streaming 20 back-to-back with the consumer always ready
    nout = 0;
    peak_inf = 0;
    peak_fifo = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      in_valid = (i < 20);
      tag = WIDTH'(32'h100 + i);
      settle();
      if (i < 20) check("stream_in_ready", 32'(in_ready), 1);
      if (int'(inflight) > peak_inf) peak_inf = int'(inflight);
      if (int'(fifo_count) > peak_fifo) peak_fifo = int'(fifo_count);
      if (out_valid) begin
        check("stream_data", 32'(out_data), 32'h100 + nout);
        nout++;
      end
      next();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("stream_count_out", nout, 20);
    check("stream_peak_inflight", peak_inf, 5);
    check("stream_fifo_le1", 32'(peak_fifo <= 1), 1);

    // 4: backpressure, consumer stalled
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      tag = WIDTH'(32'h200 + i);
      settle();
      check("bp_issue", 32'(issue), 32'(i < 8));
      next();
    end
    in_valid = 1'b0;
    next();
    next();
    next();
    settle();
    check("bp_fifo_full", 32'(fifo_count), 8);
    check("bp_inflight", 32'(inflight), 0);
    check("bp_in_ready_low", 32'(in_ready), 0);
    out_ready = 1'b1;
    settle();
    check("bp_same_cycle_ready", 32'(in_ready), 0);
    check("bp_head", 32'(out_data), 32'h200);
    next();
    out_ready = 1'b0;
    settle();
    check("bp_next_cycle_ready", 32'(in_ready), 1);
    check("bp_count_after_pop", 32'(fifo_count), 7);
    out_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      settle();
      check("bp_drain", 32'(out_data), 32'h200 + i);
      next();
    end
    out_ready = 1'b0;
    settle();
    check("bp_empty", 32'(out_valid), 0);

    // 5: issue, capture and pop in one cycle at fifo_count=3, inflight=4
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      tag = WIDTH'(32'h300 + i);
      next();
    end
    in_valid = 1'b0;
    next();
    settle();
    check("sim_pre_count", 32'(fifo_count), 3);
    check("sim_pre_inflight", 32'(inflight), 4);
    in_valid = 1'b1;
    tag = 10'h307;
    out_ready = 1'b1;
    settle();
    check("sim_issue", 32'(issue), 1);
    check("sim_head", 32'(out_data), 32'h300);
    next();
    in_valid = 1'b0;
    out_ready = 1'b0;
    settle();
    check("sim_post_count", 32'(fifo_count), 3);
    check("sim_post_inflight", 32'(inflight), 4);
    check("sim_post_head", 32'(out_data), 32'h301);
    nout = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      settle();
      if (out_valid) begin
        check("sim_drain", 32'(out_data), 32'h301 + nout);
        nout++;
      end
      next();
    end
    out_ready = 1'b0;
    check("sim_drain_total", nout, 7);

    // 6: reset mid-stream with 2 buffered and 4 in flight
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      tag = WIDTH'(32'h040 + i);
      next();
    end
    in_valid = 1'b0;
    next();
    settle();
    check("mid_pre_count", 32'(fifo_count), 2);
    check("mid_pre_inflight", 32'(inflight), 4);
    #2;
    rst = 1'b0;
    settle();
    check("mid_out_valid", 32'(out_valid), 0);
    check("mid_in_ready", 32'(in_ready), 0);
    check("mid_count", 32'(fifo_count), 0);
    check("mid_inflight", 32'(inflight), 0);
    next();
    rst = 1'b1;
    in_valid = 1'b1;
    tag = 10'h0AA;
    settle();
    check("mid_rel_ready", 32'(in_ready), 1);
    check("mid_rel_issue", 32'(issue), 1);
    next();
    in_valid = 1'b0;
    for (int i = 1; i <= LATENCY; i++) begin
      settle();
      check("mid_no_stale", 32'(out_valid), 0);
      next();
    end
    settle();
    check("mid_first_valid", 32'(out_valid), 1);
    check("mid_first_data", 32'(out_data), 32'h0AA);
    check("mid_first_count", 32'(fifo_count), 1);
    out_ready = 1'b1;
    next();
    out_ready = 1'b0;
    settle();
    check("mid_final_empty", 32'(out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
